banked_regfile: RTL and testbench

BANKED_REGFILE -- requirements
Module: banked_regfile

---
 rtl/banked_regfile_pkg.sv | 32 +++
 rtl/reg_bank_map.sv | 13 +
 rtl/banked_regfile.sv | 93 +++++++++
 tb/tb_banked_regfile.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/banked_regfile_pkg.sv
// banked_regfile_pkg: mode encodings, CPSR fields, FSM states and physical register layout
package banked_regfile_pkg;
  localparam logic [4:0] MODE_USR = 5'b10000;
  localparam logic [4:0] MODE_FIQ = 5'b10001;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_UND = 5'b11011;
  localparam logic [4:0] MODE_SYS = 5'b11111;
  localparam int CPSR_NZCV_LSB = 28;
  localparam int CPSR_I = 7;
  localparam int CPSR_F = 6;
  localparam logic [31:0] CPSR_RESET = 32'h0000_00D3;
  localparam int NUM_SPSR = 5;
  localparam int IDX_W = 5;
  localparam int PHYS_N = 31;
  localparam logic [IDX_W-1:0] FIQ_BASE = 5'd13;
  localparam logic [IDX_W-1:0] R13_BASE = 5'd18;
  localparam logic [IDX_W-1:0] PC_IDX = 5'd30;
  typedef enum logic [1:0] {S_IDLE, S_SAVE, S_SWITCH} state_t;
  // R13/R14 bank number; USR, SYS and unknown encodings share bank 0
  function automatic logic [2:0] bank_of(input logic [4:0] m);
    return m == MODE_FIQ ? 3'd1 : m == MODE_IRQ ? 3'd2 : m == MODE_SVC ? 3'd3 :
           m == MODE_ABT ? 3'd4 : m == MODE_UND ? 3'd5 : 3'd0;
  endfunction
  function automatic logic has_spsr(input logic [4:0] m);
    return bank_of(m) != 3'd0;
  endfunction
  function automatic logic [2:0] spsr_idx(input logic [4:0] m);
    return bank_of(m) - 3'd1;
  endfunction
endpackage

// File: rtl/reg_bank_map.sv
// reg_bank_map: resolves (mode, logical register) to a physical register index
module reg_bank_map import banked_regfile_pkg::*; (
  input  logic [4:0]       mode_i,
  input  logic [3:0]       addr_i,
  output logic [IDX_W-1:0] idx_o
);
  // Layout: R0-R7 at 0-7, R8-R12 user at 8-12, FIQ at 13-17, R13/R14 pairs per bank from 18, PC at 30
  always_comb
    idx_o = addr_i == 4'd15 ? PC_IDX
          : addr_i >= 4'd13 ? R13_BASE + {1'b0, bank_of(mode_i), ~addr_i[0]}
          : (addr_i >= 4'd8 && mode_i == MODE_FIQ) ? FIQ_BASE + {2'b0, addr_i[2:0]}
          : {1'b0, addr_i};
endmodule

// File: rtl/banked_regfile.sv
// banked_regfile: ARM-style banked register file with CPSR/SPSR and exception entry; define REGFILE_BYPASS_EN to forward same-cycle writes to reads
module banked_regfile import banked_regfile_pkg::*; #(
  parameter int DATA_W  = 32,
  parameter int NUM_RD  = 3,
  parameter int PC_STEP = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_RD*4-1:0]      rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [3:0]               wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     flag_we,
  input  logic [3:0]               nzcv,
  input  logic                     pc_inc,
  input  logic                     exc_req,
  input  logic [4:0]               exc_mode,
  input  logic [DATA_W-1:0]        exc_lr,
  input  logic                     exc_ret,
  output logic                     busy,
  output logic                     exc_ack,
  output logic [DATA_W-1:0]        cpsr,
  output logic [DATA_W-1:0]        pc
);
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  logic [DATA_W-1:0] regs_q [PHYS_N];
  logic [DATA_W-1:0] spsr_q [NUM_SPSR];
  logic [DATA_W-1:0] cpsr_q, lat_cpsr_q, lat_lr_q;
  logic [4:0]        lat_mode_q, cur_mode;
  logic              ack_q, wr_act, req_ok, ret_ok;
  state_t            state_q;
  logic [IDX_W-1:0]  w_idx;
  logic [IDX_W-1:0]  r_idx [NUM_RD];
  assign cur_mode = cpsr_q[4:0];
  assign busy     = state_q != S_IDLE;
  assign wr_act   = wr_en && !busy;
  assign req_ok   = exc_req && !busy && has_spsr(exc_mode);
  assign ret_ok   = exc_ret && !busy && !req_ok && has_spsr(cur_mode);
  assign exc_ack  = ack_q;
  assign cpsr     = cpsr_q;
  assign pc       = regs_q[PC_IDX];
  reg_bank_map u_wmap (.mode_i(cur_mode), .addr_i(wr_addr), .idx_o(w_idx));
  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    reg_bank_map u_rmap (.mode_i(cur_mode), .addr_i(rd_addr[r*4+:4]), .idx_o(r_idx[r]));
    assign rd_data[r*DATA_W+:DATA_W] = (BYPASS && wr_act && w_idx == r_idx[r]) ? wr_data : regs_q[r_idx[r]];
  end
  // Register/PC/CPSR updates and the IDLE -> SAVE -> SWITCH exception sequence; later writes to PC win over pc_inc
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < PHYS_N; i++) regs_q[i] <= '0;
      for (int i = 0; i < NUM_SPSR; i++) spsr_q[i] <= '0;
      cpsr_q     <= DATA_W'(CPSR_RESET);
      lat_cpsr_q <= '0;
      lat_lr_q   <= '0;
      lat_mode_q <= '0;
      ack_q      <= 1'b0;
      state_q    <= S_IDLE;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        S_SAVE: begin
          spsr_q[spsr_idx(lat_mode_q)] <= lat_cpsr_q;
          regs_q[R13_BASE + {1'b0, bank_of(lat_mode_q), 1'b1}] <= lat_lr_q;
          ack_q   <= 1'b1;
          state_q <= S_SWITCH;
        end
        S_SWITCH: begin
          cpsr_q[4:0]    <= lat_mode_q;
          cpsr_q[CPSR_I] <= 1'b1;
          cpsr_q[CPSR_F] <= cpsr_q[CPSR_F] | (lat_mode_q == MODE_FIQ);
          state_q        <= S_IDLE;
        end
        default: begin
          if (pc_inc) regs_q[PC_IDX] <= regs_q[PC_IDX] + DATA_W'(PC_STEP);
          if (wr_en) regs_q[w_idx] <= wr_data;
          if (ret_ok) cpsr_q <= spsr_q[spsr_idx(cur_mode)];
          else if (flag_we) cpsr_q[CPSR_NZCV_LSB+:4] <= nzcv;
          if (req_ok) begin
            lat_mode_q <= exc_mode;
            lat_lr_q   <= exc_lr;
            lat_cpsr_q <= cpsr_q;
            state_q    <= S_SAVE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_banked_regfile.sv
// tb_banked_regfile: randomized and directed scoreboard bench against a logical-register reference model
module tb_banked_regfile;
  localparam logic [4:0] USR = 5'b10000, FIQ = 5'b10001, IRQ = 5'b10010, SVC = 5'b10011;
  localparam logic [4:0] ABT = 5'b10111, UND = 5'b11011, SYS = 5'b11111;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef struct packed {
    logic [95:0] rd;
    logic [31:0] cpsr;
    logic [31:0] pc;
    logic        busy;
    logic        ack;
  } exp_t;

  logic        clock = 1'b0, reset = 1'b1;
  logic [11:0] rd_addr = '0;
  logic [95:0] rd_data;
  logic        wr_en = 1'b0, flag_we = 1'b0, pc_inc = 1'b0, exc_req = 1'b0, exc_ret = 1'b0;
  logic [3:0]  wr_addr = '0, nzcv = '0;
  logic [31:0] wr_data = '0, exc_lr = '0;
  logic [4:0]  exc_mode = '0;
  logic        busy, exc_ack;
  logic [31:0] cpsr, pc;
  int          checks = 0, errors = 0;
  exp_t        q[$];

  logic [31:0] gpr [8];
  logic [31:0] ubank [5];
  logic [31:0] fbank [5];
  logic [31:0] r13 [logic [4:0]];
  logic [31:0] r14 [logic [4:0]];
  logic [31:0] spsr [logic [4:0]];
  logic [31:0] m_pc, m_cpsr, l_lr, l_cpsr;
  logic [4:0]  l_mode;
  int          cnt;

  always #5 clock = ~clock;

  banked_regfile dut (
    .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .flag_we(flag_we), .nzcv(nzcv),
    .pc_inc(pc_inc), .exc_req(exc_req), .exc_mode(exc_mode), .exc_lr(exc_lr), .exc_ret(exc_ret),
    .busy(busy), .exc_ack(exc_ack), .cpsr(cpsr), .pc(pc)
  );

  function automatic logic [4:0] key(input logic [4:0] m);
    return m == SYS ? USR : m;
  endfunction
  function automatic logic has_spsr(input logic [4:0] m);
    return m inside {FIQ, IRQ, SVC, ABT, UND};
  endfunction
  function automatic logic valid_mode(input logic [4:0] m);
    return has_spsr(m) || m == USR || m == SYS;
  endfunction
  function automatic logic [11:0] ra(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    return {c, b, a};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] m, input logic [3:0] a);
    if (a == 4'd15) return m_pc;
    if (a < 4'd8) return gpr[int'(a)];
    if (a < 4'd13) return m == FIQ ? fbank[int'(a) - 8] : ubank[int'(a) - 8];
    return a == 4'd13 ? r13[key(m)] : r14[key(m)];
  endfunction

  task automatic m_write(input logic [4:0] m, input logic [3:0] a, input logic [31:0] d);
    if (a == 4'd15) m_pc = d;
    else if (a < 4'd8) gpr[int'(a)] = d;
    else if (a < 4'd13) begin
      if (m == FIQ) fbank[int'(a) - 8] = d;
      else ubank[int'(a) - 8] = d;
    end else if (a == 4'd13) r13[key(m)] = d;
    else r14[key(m)] = d;
  endtask

  task automatic m_reset();
    logic [4:0] banks [6];
    banks = '{USR, FIQ, IRQ, SVC, ABT, UND};
    foreach (gpr[i]) gpr[i] = '0;
    foreach (ubank[i]) ubank[i] = '0;
    foreach (fbank[i]) fbank[i] = '0;
    foreach (banks[i]) begin
      r13[banks[i]] = '0;
      r14[banks[i]] = '0;
      if (has_spsr(banks[i])) spsr[banks[i]] = '0;
    end
    m_pc = '0;
    m_cpsr = 32'h0000_00D3;
    cnt = 0;
  endtask

  // Advance the model by one clock edge using the current inputs
  task automatic m_step();
    logic [4:0] cur;
    cur = m_cpsr[4:0];
    if (reset) m_reset();
    else if (cnt == 2) begin
      spsr[l_mode] = l_cpsr;
      r14[l_mode] = l_lr;
      cnt = 1;
    end else if (cnt == 1) begin
      m_cpsr[4:0] = l_mode;
      m_cpsr[7] = 1'b1;
      if (l_mode == FIQ) m_cpsr[6] = 1'b1;
      cnt = 0;
    end else begin
      if (pc_inc) m_pc = m_pc + 32'd4;
      if (wr_en) m_write(cur, wr_addr, wr_data);
      if (exc_req && has_spsr(exc_mode)) begin
        l_mode = exc_mode;
        l_lr = exc_lr;
        l_cpsr = m_cpsr;
        cnt = 2;
        if (flag_we) m_cpsr[31:28] = nzcv;
      end else if (exc_ret && has_spsr(cur)) m_cpsr = spsr[cur];
      else if (flag_we) m_cpsr[31:28] = nzcv;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic clr();
    reset = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; flag_we = 1'b0; nzcv = '0;
    pc_inc = 1'b0; exc_req = 1'b0; exc_mode = '0; exc_lr = '0; exc_ret = 1'b0;
  endtask

  // Predict this cycle's outputs, queue them, then advance model and clock
  task automatic cyc();
    exp_t e;
    logic [4:0] cur;
    logic bsy;
    cur = m_cpsr[4:0];
    bsy = cnt != 0;
    for (int p = 0; p < 3; p++) begin
      logic [3:0] a;
      logic [31:0] v;
      a = rd_addr[p*4+:4];
      v = m_read(cur, a);
      if (BYP && !bsy && wr_en && wr_addr == a) v = wr_data;
      e.rd[p*32+:32] = v;
    end
    e.cpsr = m_cpsr;
    e.pc = m_pc;
    e.busy = bsy;
    e.ack = cnt == 1;
    q.push_back(e);
    m_step();
    @(posedge clock);
    #1;
  endtask

  // Monitor: compare the DUT against the queued prediction mid-cycle
  always @(negedge clock) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      for (int p = 0; p < 3; p++) check($sformatf("rd%0d", p), rd_data[p*32+:32], e.rd[p*32+:32]);
      check("cpsr", cpsr, e.cpsr);
      check("pc", pc, e.pc);
      check("busy", {31'b0, busy}, {31'b0, e.busy});
      check("exc_ack", {31'b0, exc_ack}, {31'b0, e.ack});
    end
  end

  initial begin
    logic [4:0] cur;
    repeat (2) @(posedge clock);
    #1;
    m_reset();
    check("rst_cpsr", cpsr, 32'h0000_00D3);
    check("rst_pc", pc, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    clr(); rd_addr = ra(13, 14, 15); cyc();
    // SVC R13 write, then IRQ entry
    clr(); wr_en = 1'b1; wr_addr = 4'd13; wr_data = 32'h1111; rd_addr = ra(13, 0, 0); cyc();
    clr(); exc_req = 1'b1; exc_mode = IRQ; exc_lr = 32'h80; cyc();
    check("save_busy", {31'b0, busy}, 32'h1);
    check("save_ack", {31'b0, exc_ack}, 32'h0);
    clr(); cyc();
    check("switch_ack", {31'b0, exc_ack}, 32'h1);
    clr(); wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'hDEAD; cyc();
    check("irq_cpsr", cpsr, 32'h0000_00D2);
    check("irq_busy", {31'b0, busy}, 32'h0);
    clr(); rd_addr = ra(13, 14, 2); cyc();
    // Return to SVC, then FIQ bank isolation
    clr(); exc_ret = 1'b1; cyc();
    check("ret_svc", cpsr, 32'h0000_00D3);
    clr(); exc_req = 1'b1; exc_mode = FIQ; exc_lr = 32'h44; cyc();
    clr(); cyc();
    clr(); cyc();
    check("fiq_cpsr", cpsr, 32'h0000_00D1);
    clr(); wr_en = 1'b1; wr_addr = 4'd8; wr_data = 32'hAA; cyc();
    clr(); exc_ret = 1'b1; rd_addr = ra(8, 14, 13); cyc();
    clr(); rd_addr = ra(8, 13, 14); cyc();
    clr(); exc_req = 1'b1; exc_mode = FIQ; exc_lr = 32'h48; cyc();
    clr(); cyc();
    clr(); cyc();
    clr(); rd_addr = ra(8, 14, 9); cyc();
    clr(); exc_ret = 1'b1; cyc();
    // PC wrap and R15 write priority
    clr(); wr_en = 1'b1; wr_addr = 4'd15; wr_data = 32'hFFFF_FFFC; cyc();
    check("pc_load", pc, 32'hFFFF_FFFC);
    clr(); pc_inc = 1'b1; rd_addr = ra(15, 15, 15); cyc();
    check("pc_wrap", pc, 32'h0);
    clr(); pc_inc = 1'b1; wr_en = 1'b1; wr_addr = 4'd15; wr_data = 32'h100; rd_addr = ra(15, 0, 0); cyc();
    check("pc_prio", pc, 32'h100);
    // Same-cycle write/read of R3
    clr(); wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h7; cyc();
    clr(); wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h5; rd_addr = ra(3, 3, 3); cyc();
    clr(); rd_addr = ra(3, 0, 0); cyc();
    // exc_req beats exc_ret; flags with a request land before the mode switch
    clr(); exc_req = 1'b1; exc_mode = ABT; exc_ret = 1'b1; flag_we = 1'b1; nzcv = 4'hA; cyc();
    clr(); cyc();
    clr(); cyc();
    check("abt_cpsr", cpsr, 32'hA000_00D7);
    clr(); exc_ret = 1'b1; flag_we = 1'b1; nzcv = 4'h5; cyc();
    check("ret_flags", cpsr, 32'h0000_00D3);
    // Invalid or USR/SYS requests are ignored
    clr(); exc_req = 1'b1; exc_mode = USR; cyc();
    check("req_usr", {31'b0, busy}, 32'h0);
    clr(); exc_req = 1'b1; exc_mode = SYS; cyc();
    check("req_sys", {31'b0, busy}, 32'h0);
    clr(); exc_req = 1'b1; exc_mode = 5'b00101; cyc();
    check("req_bad", {31'b0, busy}, 32'h0);
    // Reset while in SAVE
    clr(); exc_req = 1'b1; exc_mode = IRQ; exc_lr = 32'h99; cyc();
    clr(); reset = 1'b1; cyc();
    check("rst_save_cpsr", cpsr, 32'h0000_00D3);
    check("rst_save_busy", {31'b0, busy}, 32'h0);
    clr(); exc_ret = 1'b1; cyc();
    check("rst_spsr_svc", cpsr, 32'h0);
    clr(); reset = 1'b1; cyc();
    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cur = m_cpsr[4:0];
      clr();
      reset = $urandom_range(0, 299) == 0;
      rd_addr = 12'($urandom);
      wr_en = 1'($urandom_range(0, 1));
      wr_addr = 4'($urandom);
      if ($urandom_range(0, 3) == 0) wr_addr = rd_addr[3:0];
      wr_data = $urandom;
      flag_we = $urandom_range(0, 3) == 0;
      nzcv = 4'($urandom);
      pc_inc = $urandom_range(0, 2) == 0;
      exc_req = $urandom_range(0, 11) == 0;
      case ($urandom_range(0, 7))
        0: exc_mode = USR;
        1: exc_mode = FIQ;
        2: exc_mode = IRQ;
        3: exc_mode = SVC;
        4: exc_mode = ABT;
        5: exc_mode = UND;
        6: exc_mode = SYS;
        default: exc_mode = 5'($urandom);
      endcase
      exc_lr = $urandom;
      exc_ret = $urandom_range(0, 9) == 0 && (!exc_req || has_spsr(exc_mode)) &&
                (!has_spsr(cur) || valid_mode(spsr[cur][4:0]));
      cyc();
    end
    clr(); cyc();
    check("queue_drained", q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
